// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style display model: opcode masks,
// DDRAM line geometry, FSM state encodings and cursor arithmetic.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_INIT0,
        ST_INIT1,
        ST_INIT2,
        ST_NIB_HI,
        ST_NIB_LO
    } lcd_state_t;

    localparam logic [7:0] OP_SET_DDRAM = 8'h80;
    localparam logic [7:0] OP_SET_CGRAM = 8'h40;
    localparam logic [7:0] OP_FUNC_SET  = 8'h20;
    localparam logic [7:0] OP_SHIFT     = 8'h10;
    localparam logic [7:0] OP_DISP_CTRL = 8'h08;
    localparam logic [7:0] OP_ENTRY     = 8'h04;
    localparam logic [7:0] OP_HOME      = 8'h02;
    localparam logic [7:0] OP_CLEAR     = 8'h01;

    localparam logic [7:0] BLANK      = 8'h20;
    localparam int         LINE_LEN   = 40;
    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE1_END  = LINE1_BASE + 7'(LINE_LEN - 1);
    localparam logic [6:0] LINE2_END  = LINE2_BASE + 7'(LINE_LEN - 1);

    // Step the address counter, hopping between the two 40-column windows.
    function automatic logic [6:0] cur_step(input logic [6:0] c, input logic up);
        if (up) begin
            if (c == LINE1_END) return LINE2_BASE;
            if (c == LINE2_END) return LINE1_BASE;
            return c + 7'd1;
        end
        if (c == LINE1_BASE) return LINE2_END;
        if (c == LINE2_BASE) return LINE1_END;
        return c - 7'd1;
    endfunction

    function automatic logic [6:0] cur_sanitize(input logic [6:0] c);
        if (c <= LINE1_END || (c >= LINE2_BASE && c <= LINE2_END)) return c;
        return LINE1_BASE;
    endfunction

endpackage

// File: rtl/lcd_ddram_2p.sv
// 128x8 display data RAM: one write port, one registered read port.
// A read colliding with a write to the same address returns the old byte.
module lcd_ddram_2p (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [6:0] wa,
    input  logic [7:0] wd,
    input  logic [6:0] ra,
    output logic [7:0] rd
);

    logic [7:0] mem [128];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    always_ff @(posedge clk) begin
        if (rst) rd <= '0;
        else     rd <= mem[ra];
    end

endmodule

// File: rtl/lcd_hd44780_rx.sv
// Responder end of the 4-bit character-LCD bus: samples the strobe, runs the
// init/nibble FSM, decodes commands, tracks busy time and flags violations.
module lcd_hd44780_rx
    import lcd_pkg::*;
#(
    parameter int E_MIN_CYC    = 12,
    parameter int NIB_GAP_CYC  = 50,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [3:0] lcd_db,
    input  logic       sf_ce0,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       byte_valid,
    output logic       byte_rs,
    output logic [7:0] byte_data,
    output logic [6:0] cursor,
    output logic       disp_on,
    output logic       busy,
    output logic       err_timing,
    output logic       err_bus
);

    localparam int CW     = 16;
    localparam int WMAX   = (CLR_WAIT_CYC > CMD_WAIT_CYC) ? CLR_WAIT_CYC : CMD_WAIT_CYC;
    localparam int BW     = $clog2(WMAX + 1);
    localparam logic [CW-1:0] E_MIN   = CW'(E_MIN_CYC);
    localparam logic [CW-1:0] NIB_GAP = CW'(NIB_GAP_CYC);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    logic          e_r, e_d, rs_r, rs_d, rw_r, rw_d, ce_r, ce_d;
    logic [3:0]    db_r, db_d;
    logic [CW-1:0] hi_cnt, gap_cnt, gap_lat;
    logic          e_rise, e_fall;

    // All bus pins travel together so the fall cycle sees the last high sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            {e_r, e_d, rs_r, rs_d, rw_r, rw_d, ce_r, ce_d} <= '0;
            db_r    <= '0;
            db_d    <= '0;
            hi_cnt  <= '0;
            gap_cnt <= '0;
            gap_lat <= '0;
        end else begin
            {e_r, rs_r, rw_r, ce_r, db_r} <= {lcd_e, lcd_rs, lcd_rw, sf_ce0, lcd_db};
            {e_d, rs_d, rw_d, ce_d, db_d} <= {e_r, rs_r, rw_r, ce_r, db_r};
            hi_cnt  <= e_r ? sat_inc(hi_cnt) : '0;
            gap_cnt <= e_r ? '0 : sat_inc(gap_cnt);
            if (e_rise) gap_lat <= gap_cnt;
        end
    end

    assign e_rise = e_r & ~e_d;
    assign e_fall = e_d & ~e_r;

    lcd_state_t    state;
    logic [3:0]    hi_nib;
    logic          inc;
    logic [BW-1:0] busy_cnt;
    logic          fill_act;
    logic [6:0]    fill_cnt;
    logic          wr_en;
    logic [6:0]    wr_addr;
    logic [7:0]    wr_data;
    logic [7:0]    nib_byte;
    logic          clr_home;

    assign nib_byte = {hi_nib, db_d};
    assign clr_home = (nib_byte[7:2] == 6'd0) && (nib_byte[1:0] != 2'd0);
    assign busy     = fill_act | (busy_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_INIT0;
            hi_nib     <= '0;
            inc        <= 1'b1;
            busy_cnt   <= '0;
            fill_act   <= 1'b1;
            fill_cnt   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            byte_valid <= 1'b0;
            byte_rs    <= 1'b0;
            byte_data  <= '0;
            cursor     <= '0;
            disp_on    <= 1'b0;
            err_timing <= 1'b0;
            err_bus    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            wr_en      <= 1'b0;
            if (busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;
            // A data write landing on the fill slot takes it; otherwise the fill stalls a cycle.
            if (fill_act && (!wr_en || wr_addr == fill_cnt)) begin
                fill_cnt <= fill_cnt + 7'd1;
                if (fill_cnt == 7'h7f) fill_act <= 1'b0;
            end
            if (e_fall) begin
                if (rw_d || !ce_d) begin
                    err_bus <= 1'b1;
                end else begin
                    if (hi_cnt < E_MIN) err_timing <= 1'b1;
                    case (state)
                        ST_INIT0, ST_INIT1, ST_INIT2: begin
                            byte_valid <= 1'b1;
                            byte_rs    <= rs_d;
                            byte_data  <= {db_d, 4'h0};
                            if (!rs_d) begin
                                if (state == ST_INIT0 && db_d == 4'h3) state <= ST_INIT1;
                                if (state == ST_INIT1 && db_d == 4'h3) state <= ST_INIT2;
                                if (state == ST_INIT2 && db_d == 4'h2) state <= ST_NIB_HI;
                            end
                        end
                        ST_NIB_HI: begin
                            hi_nib <= db_d;
                            state  <= ST_NIB_LO;
                        end
                        default: begin
                            if (gap_lat < NIB_GAP || busy) err_timing <= 1'b1;
                            byte_valid <= 1'b1;
                            byte_rs    <= rs_d;
                            byte_data  <= nib_byte;
                            state      <= ST_NIB_HI;
                            busy_cnt   <= clr_home ? BW'(CLR_WAIT_CYC) : BW'(CMD_WAIT_CYC);
                            if (rs_d) begin
                                wr_en   <= 1'b1;
                                wr_addr <= cursor;
                                wr_data <= nib_byte;
                                cursor  <= cur_step(cursor, inc);
                            end else if (|(nib_byte & OP_SET_DDRAM)) begin
                                cursor <= cur_sanitize(nib_byte[6:0]);
                            end else if (|(nib_byte & (OP_SET_CGRAM | OP_FUNC_SET | OP_SHIFT))) begin
                                cursor <= cursor;
                            end else if (|(nib_byte & OP_DISP_CTRL)) begin
                                disp_on <= nib_byte[2];
                            end else if (|(nib_byte & OP_ENTRY)) begin
                                inc <= nib_byte[1];
                            end else if (|(nib_byte & OP_HOME)) begin
                                cursor <= LINE1_BASE;
                            end else if (|(nib_byte & OP_CLEAR)) begin
                                cursor   <= LINE1_BASE;
                                inc      <= 1'b1;
                                fill_act <= 1'b1;
                                fill_cnt <= '0;
                            end
                        end
                    endcase
                end
            end
        end
    end

    lcd_ddram_2p u_ddram (
        .clk (clk),
        .rst (rst),
        .we  (wr_en | fill_act),
        .wa  (wr_en ? wr_addr : fill_cnt),
        .wd  (wr_en ? wr_data : BLANK),
        .ra  (rd_addr),
        .rd  (rd_data)
    );

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// Randomized bench for lcd_hd44780_rx against a line/column display model.
module tb_lcd_hd44780_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0, sf_ce0 = 1'b1;
    logic [3:0] lcd_db = '0;
    logic [6:0] rd_addr = '0;
    logic [7:0] rd_data, byte_data;
    logic       byte_valid, byte_rs, disp_on, busy, err_timing, err_bus;
    logic [6:0] cursor;

    lcd_hd44780_rx #(
        .E_MIN_CYC(12), .NIB_GAP_CYC(50), .CMD_WAIT_CYC(200), .CLR_WAIT_CYC(1000)
    ) dut (
        .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_db(lcd_db), .sf_ce0(sf_ce0), .rd_addr(rd_addr), .rd_data(rd_data),
        .byte_valid(byte_valid), .byte_rs(byte_rs), .byte_data(byte_data),
        .cursor(cursor), .disp_on(disp_on), .busy(busy),
        .err_timing(err_timing), .err_bus(err_bus)
    );

    always #5 clk = ~clk;

    int         bv_cnt = 0;
    logic [7:0] last_bd = '0;
    always @(posedge clk) begin
        if (byte_valid) begin
            bv_cnt  <= bv_cnt + 1;
            last_bd <= byte_data;
        end
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Display model: cursor held as (line, column), RAM as a flat array.
    logic [7:0] m_ram [128];
    int m_line, m_col, m_init, m_bv = 0;
    bit m_inc, m_disp;

    function automatic int m_cur();
        return m_line * 64 + m_col;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 128; i++) m_ram[i] = 8'h20;
        m_line = 0; m_col = 0; m_inc = 1;
    endfunction

    function automatic void m_reset();
        m_clear();
        m_disp = 0; m_init = 0;
    endfunction

    function automatic void m_nib(input bit rs, input int n);
        m_bv++;
        if (!rs && n == ((m_init == 2) ? 2 : 3)) m_init++;
    endfunction

    function automatic void m_byte(input bit rs, input int b);
        m_bv++;
        if (rs) begin
            m_ram[m_cur()] = 8'(b);
            if (m_inc) begin
                m_col++;
                if (m_col == 40) begin m_col = 0; m_line = 1 - m_line; end
            end else if (m_col == 0) begin
                m_col = 39; m_line = 1 - m_line;
            end else m_col--;
        end else if (b >= 128) begin
            int a = b - 128;
            if (a < 40) begin m_line = 0; m_col = a; end
            else if (a >= 64 && a < 104) begin m_line = 1; m_col = a - 64; end
            else begin m_line = 0; m_col = 0; end
        end else if (b >= 16) begin
            m_disp = m_disp;
        end else if (b >= 8) m_disp = (b / 4) % 2 == 1;
        else if (b >= 4) m_inc = (b / 2) % 2 == 1;
        else if (b >= 2) begin m_line = 0; m_col = 0; end
        else if (b == 1) m_clear();
    endfunction

    task automatic strobe(input bit rs, input logic [3:0] n, input int hi, input bit rw, input bit ce);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; sf_ce0 = ce; lcd_db = n;
        repeat (2) @(negedge clk);
        lcd_e = 1'b1;
        repeat (hi) @(negedge clk);
        lcd_e = 1'b0;
        repeat (3) @(negedge clk);
        lcd_rw = 1'b0; sf_ce0 = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (4) @(negedge clk);
        while (busy && n < 5000) begin @(negedge clk); n++; end
        if (busy) chk("busy_timeout", 1, 0);
    endtask

    task automatic wr_nib(input bit rs, input logic [3:0] n);
        strobe(rs, n, 12, 0, 1);
        m_nib(rs, int'(n));
        repeat (60) @(negedge clk);
    endtask

    task automatic wr_byte(input bit rs, input logic [7:0] b, input bit wt);
        strobe(rs, b[7:4], 12, 0, 1);
        repeat (60) @(negedge clk);
        strobe(rs, b[3:0], 12, 0, 1);
        m_byte(rs, int'(b));
        if (wt) wait_idle();
    endtask

    task automatic rd(input logic [6:0] a, output logic [7:0] d);
        @(negedge clk); rd_addr = a;
        @(negedge clk); d = rd_data;
    endtask

    task automatic chk_ram(input string tag);
        logic [7:0] d;
        for (int a = 0; a < 128; a++) begin
            rd(7'(a), d);
            chk($sformatf("%s_ram%02h", tag, a), d, m_ram[a]);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_cursor"}, cursor, m_cur());
        chk({tag, "_disp"}, disp_on, m_disp);
        chk({tag, "_bvcnt"}, bv_cnt, m_bv);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; lcd_e = 1'b0;
        repeat (3) @(negedge clk); rst = 1'b0;
        m_reset();
        repeat (135) @(negedge clk);
    endtask

    task automatic do_init();
        wr_nib(0, 4'h3); wr_nib(0, 4'h3); wr_nib(0, 4'h3); wr_nib(0, 4'h2);
        wr_byte(0, 8'h28, 1); wr_byte(0, 8'h0C, 1); wr_byte(0, 8'h06, 1); wr_byte(0, 8'h01, 1);
    endtask

    initial begin
        logic [7:0] d;
        int         op, cnt;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_bv", byte_valid, 0);
        chk("rst_bdata", byte_data, 0);
        chk("rst_cursor", cursor, 0);
        chk("rst_disp", disp_on, 0);
        chk("rst_errs", {err_timing, err_bus}, 0);
        chk("rst_rdata", rd_data, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("fill_busy", busy, 1);
        repeat (135) @(negedge clk);

        do_init();
        chk_state("init");
        chk("init_bv8", bv_cnt, 8);
        chk("init_errs", {err_timing, err_bus}, 0);

        for (int i = 0; i < 5; i++) wr_byte(1, "Hello" >> (8 * (4 - i)), 1);
        for (int a = 0; a < 5; a++) begin
            rd(7'(a), d);
            chk($sformatf("hello%0d", a), d, m_ram[a]);
        end
        chk("hello_cursor", cursor, 5);

        wr_byte(0, 8'hA7, 1); wr_byte(1, 8'h41, 1); wr_byte(1, 8'h42, 1);
        rd(7'h27, d); chk("wrap_27", d, 8'h41);
        rd(7'h40, d); chk("wrap_40", d, 8'h42);
        chk("wrap_cursor", cursor, 7'h41);

        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 19);
            if (op < 10)      wr_byte(1, 8'($urandom_range(33, 126)), 1);
            else if (op < 14) wr_byte(0, 8'h80 | 8'($urandom_range(0, 127)), 1);
            else if (op < 17) wr_byte(0, 8'h04 | 8'($urandom_range(0, 3)), 1);
            else if (op < 19) wr_byte(0, 8'h08 | 8'($urandom_range(0, 7)), 1);
            else              wr_byte(0, 8'h01, 1);
        end
        chk_state("rand");
        chk("rand_errs", {err_timing, err_bus}, 0);
        chk_ram("rand");

        strobe(1, 4'h4, 12, 1, 1);
        repeat (60) @(negedge clk);
        chk("rw_errbus", err_bus, 1);
        chk_state("rw");
        chk("rw_errt", err_timing, 0);

        do_reset(); do_init();
        strobe(1, 4'h4, 12, 0, 0);
        repeat (60) @(negedge clk);
        chk("ce_errbus", err_bus, 1);
        chk_state("ce");

        do_reset(); do_init();
        chk("short_pre", err_timing, 0);
        strobe(1, 4'h5, 6, 0, 1);
        repeat (60) @(negedge clk);
        strobe(1, 4'h1, 12, 0, 1);
        m_byte(1, 8'h51);
        wait_idle();
        chk("short_errt", err_timing, 1);
        repeat (500) @(negedge clk);
        chk("short_sticky", err_timing, 1);
        rd(7'h00, d); chk("short_accepted", d, 8'h51);
        chk_state("short");

        do_reset(); do_init();
        strobe(1, 4'h6, 12, 0, 1);
        repeat (20) @(negedge clk);
        strobe(1, 4'h1, 12, 0, 1);
        m_byte(1, 8'h61);
        wait_idle();
        chk("gap_errt", err_timing, 1);

        do_reset(); do_init();
        wr_byte(0, 8'h01, 0);
        repeat (100) @(negedge clk);
        wr_byte(1, 8'h5A, 1);
        chk("busy_errt", err_timing, 1);
        rd(7'h00, d); chk("busy_exec", d, 8'h5A);
        chk_state("busy");

        strobe(1, 4'h7, 12, 0, 1);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_out", {byte_valid, byte_rs, byte_data, cursor, disp_on, err_timing, err_bus}, 0);
        chk("mid_rst_rdata", rd_data, 0);
        rst = 1'b0;
        m_reset();
        repeat (135) @(negedge clk);
        cnt = 0;
        for (int a = 0; a < 128; a++) begin
            rd(7'(a), d);
            if (d != 8'h20) cnt++;
        end
        chk("mid_rst_blank", cnt, 0);
        wr_nib(0, 4'h8); wr_nib(0, 4'h5);
        chk("mid_rst_init0_bd", last_bd, 8'h50);
        chk_state("mid_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout got=%0d exp=0", 1);
        $fatal(1, "timeout");
    end

endmodule
